aesl_deadlock_report_ctrl: RTL and testbench

//   Top-level scheduler for the per-instance deadlock monitors in the cosim bench.

---
 rtl/aesl_deadlock_report_ctrl_if.sv | 28 ++
 rtl/aesl_deadlock_report_ctrl.sv | 162 ++++++++++++++++
 tb/tb_aesl_deadlock_report_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/aesl_deadlock_report_ctrl_if.sv
// Report channel from the deadlock scheduler to the bench reporter:
// the payload is qualified by valid and consumed by ready.
interface aesl_deadlock_report_ctrl_if #(
    parameter int IDX_W  = 2,
    parameter int AXIS_W = 13
);
    logic              report_valid;
    logic              report_ready;
    logic [IDX_W-1:0]  report_idx;
    logic [AXIS_W-1:0] report_chan;
    logic [31:0]       report_cycle;

    modport master (
        output report_valid,
        output report_idx,
        output report_chan,
        output report_cycle,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_idx,
        input  report_chan,
        input  report_cycle,
        output report_ready
    );
endinterface

// File: rtl/aesl_deadlock_report_ctrl.sv
// Round-robin deadlock scheduler: confirms a persistently blocked monitor,
// reports its index, AXIS snapshot and cycle stamp once, then halts.
module aesl_deadlock_report_ctrl #(
    parameter int NUM_MON = 4,
    parameter int AXIS_W  = 13,
    parameter int THRESH  = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_MON-1:0]   mon_block,
    input  logic [AXIS_W-1:0]    axis_block_sigs,
    aesl_deadlock_report_ctrl_if.master rpt,
    output logic                 deadlock,
    output logic                 busy
);
    localparam int IDX_W = (NUM_MON > 2) ? $clog2(NUM_MON) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        CONFIRM = 3'd2,
        REPORT  = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  cand;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       cyc;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              load_cand;
    logic              inc_cnt;
    logic              miss;
    logic              abort;
    logic              confirm;
    logic              accept;

    logic              valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [AXIS_W-1:0] chan_q;
    logic [31:0]       cycle_q;
    logic              deadlock_q;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_MON);
    endfunction

    // Descending scan so the smallest rotational distance from ptr is the last writer.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_MON - 1; k >= 0; k--) begin
            if (mon_block[wrap_idx(int'(ptr) + k)]) begin
                hit     = 1'b1;
                hit_idx = wrap_idx(int'(ptr) + k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Dropping enable takes priority over both a new candidate and a confirmation.
    always_comb begin
        state_next = state;
        load_cand  = 1'b0;
        inc_cnt    = 1'b0;
        miss       = 1'b0;
        abort      = 1'b0;
        confirm    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (hit) begin
                    load_cand  = 1'b1;
                    state_next = CONFIRM;
                end
            end
            CONFIRM: begin
                if (!enable) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (!mon_block[cand]) begin
                    miss       = 1'b1;
                    state_next = SCAN;
                end else if (cnt == CNT_W'(THRESH - 1)) begin
                    confirm    = 1'b1;
                    state_next = REPORT;
                end else begin
                    inc_cnt    = 1'b1;
                end
            end
            REPORT: begin
                if (rpt.report_ready) begin
                    accept     = 1'b1;
                    state_next = HALT;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            cand       <= '0;
            cnt        <= '0;
            cyc        <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            chan_q     <= '0;
            cycle_q    <= '0;
            deadlock_q <= 1'b0;
        end else begin
            if (cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;

            if (load_cand) begin
                cand <= hit_idx;
                cnt  <= CNT_W'(1);
            end else if (inc_cnt) begin
                cnt  <= cnt + CNT_W'(1);
            end else if (miss || abort) begin
                cnt  <= '0;
            end

            if (miss) ptr <= wrap_idx(int'(cand) + 1);

            if (confirm) begin
                valid_q    <= 1'b1;
                idx_q      <= cand;
                chan_q     <= axis_block_sigs;
                cycle_q    <= cyc;
                deadlock_q <= 1'b1;
            end else if (accept) begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign rpt.report_valid = valid_q;
    assign rpt.report_idx   = idx_q;
    assign rpt.report_chan  = chan_q;
    assign rpt.report_cycle = cycle_q;
    assign deadlock         = deadlock_q;
    assign busy             = (state == CONFIRM) || (state == REPORT);

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Directed scenarios for the deadlock scheduler; expected reports are queued
// when the blocking pattern is driven and compared when report_valid rises.
module tb_aesl_deadlock_report_ctrl;
    localparam int NUM_MON = 4;
    localparam int AXIS_W  = 13;
    localparam int THRESH  = 16;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic [NUM_MON-1:0] mon_block;
    logic [AXIS_W-1:0]  axis_block_sigs;
    logic               deadlock;
    logic               busy;
    logic [31:0]        tb_cyc;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [AXIS_W-1:0] chan;
        logic [31:0]       cycle;
        int                latency;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    aesl_deadlock_report_ctrl_if #(.IDX_W(IDX_W), .AXIS_W(AXIS_W)) rpt ();

    aesl_deadlock_report_ctrl #(
        .NUM_MON(NUM_MON), .AXIS_W(AXIS_W), .THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .mon_block(mon_block),
        .axis_block_sigs(axis_block_sigs),
        .rpt(rpt),
        .deadlock(deadlock),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference cycle stamp: zero under reset, saturating count otherwise.
    always @(posedge clock) begin
        if (reset) tb_cyc <= '0;
        else if (tb_cyc != 32'hFFFF_FFFF) tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        enable           = 1'b0;
        mon_block        = '0;
        rpt.report_ready = 1'b0;
        axis_block_sigs  = AXIS_W'($urandom_range(0, (1 << AXIS_W) - 1));
        step(2);
        reset = 1'b0;
        check_output("rst_valid", 32'(rpt.report_valid), 32'd0);
        check_output("rst_deadlock", 32'(deadlock), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cycle", rpt.report_cycle, 32'd0);
    endtask

    task automatic apply_stimulus(input logic [NUM_MON-1:0] pattern);
        mon_block = pattern;
    endtask

    task automatic start_scan();
        enable = 1'b1;
        step(1);
        check_output("scan_busy", 32'(busy), 32'd0);
    endtask

    // Expected stamp is the reference cycle at the confirming edge, latency-1 edges from now.
    task automatic push_report(input logic [IDX_W-1:0] idx, input int latency);
        exp_t e;
        e.idx     = idx;
        e.chan    = axis_block_sigs;
        e.cycle   = tb_cyc + 32'(latency - 1);
        e.latency = latency;
        sb.push_back(e);
    endtask

    task automatic wait_report(output exp_t e);
        int n;
        n = 0;
        e = '{idx: '0, chan: '0, cycle: '0, latency: 0};
        check_output("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        while (!rpt.report_valid && n < e.latency + 8) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_output("latency", 32'(n), 32'(e.latency));
        check_output("rep_idx", 32'(rpt.report_idx), 32'(e.idx));
        check_output("rep_chan", 32'(rpt.report_chan), 32'(e.chan));
        check_output("rep_cycle", rpt.report_cycle, e.cycle);
        check_output("rep_deadlock", 32'(deadlock), 32'd1);
        check_output("rep_busy", 32'(busy), 32'd1);
    endtask

    task automatic handshake();
        rpt.report_ready = 1'b1;
        step(1);
        rpt.report_ready = 1'b0;
        check_output("halt_valid", 32'(rpt.report_valid), 32'd0);
        check_output("halt_busy", 32'(busy), 32'd0);
        check_output("halt_deadlock", 32'(deadlock), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Basic confirmation of monitor 2, then HALT must hold everything.
        do_reset();
        start_scan();
        apply_stimulus(4'b0100);
        push_report(2'd2, THRESH);
        wait_report(cur);
        handshake();
        enable = 1'b0;
        step(4);
        check_output("halt_hold_valid", 32'(rpt.report_valid), 32'd0);
        check_output("halt_hold_deadlock", 32'(deadlock), 32'd1);
        check_output("halt_hold_idx", 32'(rpt.report_idx), 32'd2);
        check_output("halt_hold_busy", 32'(busy), 32'd0);

        // Monitor 1 blocks only 10 cycles; ptr moves to 2 so monitor 3 beats monitor 1.
        do_reset();
        start_scan();
        apply_stimulus(4'b0010);
        step(10);
        check_output("short_busy", 32'(busy), 32'd1);
        check_output("short_valid", 32'(rpt.report_valid), 32'd0);
        apply_stimulus(4'b0000);
        step(1);
        check_output("short_back_scan", 32'(busy), 32'd0);
        apply_stimulus(4'b1010);
        push_report(2'd3, THRESH);
        wait_report(cur);

        // Reset while in REPORT clears everything; ptr restarts at 0 so monitor 1 wins.
        reset = 1'b1;
        step(1);
        check_output("mid_rst_valid", 32'(rpt.report_valid), 32'd0);
        check_output("mid_rst_deadlock", 32'(deadlock), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_idx", 32'(rpt.report_idx), 32'd0);
        check_output("mid_rst_cycle", rpt.report_cycle, 32'd0);
        reset  = 1'b0;
        enable = 1'b0;
        step(2);
        check_output("mid_rst_idle", 32'(busy), 32'd0);
        start_scan();
        push_report(2'd1, THRESH);
        wait_report(cur);
        handshake();

        // ptr advanced to 3 by a brief block on monitor 2, then 3 and 0 together.
        do_reset();
        start_scan();
        apply_stimulus(4'b0100);
        step(3);
        apply_stimulus(4'b0000);
        step(1);
        apply_stimulus(4'b1001);
        push_report(2'd3, THRESH);
        wait_report(cur);

        // Reporter stalls for 5 cycles: payload must stay frozen despite input changes.
        axis_block_sigs = ~axis_block_sigs;
        enable          = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_output("stall_valid", 32'(rpt.report_valid), 32'd1);
            check_output("stall_idx", 32'(rpt.report_idx), 32'(cur.idx));
            check_output("stall_chan", 32'(rpt.report_chan), 32'(cur.chan));
            check_output("stall_cycle", rpt.report_cycle, cur.cycle);
        end
        handshake();

        // Enable drop at cnt=8 aborts; re-enable restarts the full confirm window.
        do_reset();
        start_scan();
        apply_stimulus(4'b0001);
        step(8);
        enable = 1'b0;
        step(1);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_valid", 32'(rpt.report_valid), 32'd0);
        enable = 1'b1;
        push_report(2'd0, THRESH + 1);
        wait_report(cur);
        handshake();

        // Enable drop on the confirming edge itself: no report may appear.
        do_reset();
        start_scan();
        apply_stimulus(4'b0001);
        step(THRESH - 1);
        enable = 1'b0;
        step(1);
        check_output("race_valid", 32'(rpt.report_valid), 32'd0);
        check_output("race_deadlock", 32'(deadlock), 32'd0);
        check_output("race_busy", 32'(busy), 32'd0);
        step(20);
        check_output("race_still_idle", 32'(rpt.report_valid), 32'd0);

        check_output("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
